nn_frame_loader: RTL and testbench
==================================

# nn_frame_loader

Front-end producer for the digit-recognition core. It accepts a byte-serial 28x28 grayscale frame over a valid/ready stream and writes it into a flat pixel buffer that feeds the network's image input. It then sequences the network through reset, enable and done, and returns the recognised digit through a held result handshake. It sits between the host link (UART/camera byte stream) and the neural network top.

## Interface
- IMG_W, 28, frame width in pixels
- IMG_H, 28, frame height in pixels
- PIX_W, 8, bits per pixel
- NN_TIMEOUT, 200000, maximum cycles in RUN before the run is abandoned
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- s_valid  in  1  stream pixel valid
- s_data  in  PIX_W  pixel value, row-major order, pixel 0 = top-left
- s_last  in  1  marks the final pixel of a frame
- s_ready  out  1  stream ready; a beat transfers when s_valid && s_ready
- img_flat  out  PIX_W*IMG_W*IMG_H  pixel k at bits [PIX_W*k+PIX_W-1 : PIX_W*k]
- nn_reset  out  1  drives the network's reset
- nn_enable  out  1  drives the network's enable
- nn_digit  in  8  network digit output
- nn_done  in  1  network done (level)
- result_valid  out  1  recognised digit available
- result_digit  out  8  recognised digit
- result_ack  in  1  consumer accepts result
- frame_error  out  1  one-cycle pulse on framing error or timeout
- busy  out  1  high in CLEAR, RUN, HOLD

## Operation
- N = IMG_W*IMG_H (784). Pixel counter `cnt` is 0..N-1 and is 10 bits wide for defaults. Width is ceil(log2(N)).
- States: LOAD, SYNC, CLEAR, RUN, HOLD. Reset enters LOAD with cnt=0.
- s_ready = (state==LOAD || state==SYNC) && !reset. It is combinational.
- LOAD, accepted beat: the pixel is written to slot cnt.
  - cnt<N-1 and s_last=0: cnt++.
  - cnt<N-1 and s_last=1 (short frame): frame_error pulse, cnt<=0, stay in LOAD. Pixels already written are left stale.
  - cnt==N-1 and s_last=1: cnt<=0, go to CLEAR.
  - cnt==N-1 and s_last=0 (long frame): frame_error pulse, cnt<=0, go to SYNC.
- SYNC: accepted beats are discarded with no buffer write. An accepted beat with s_last=1 returns to LOAD.
- CLEAR: lasts exactly one cycle. nn_reset is high, then go to RUN.
- RUN: nn_enable is high. A timer counts cycles in RUN.
  - nn_done sampled high: latch result_digit<=nn_digit, go to HOLD.
  - Timer reaches NN_TIMEOUT-1 without nn_done: frame_error pulse, go to LOAD. result is not updated.
- HOLD: result_valid is high and nn_enable is low. result_ack high returns to LOAD. A new frame is not accepted until the result is acknowledged.
- nn_reset = reset || state==CLEAR. The network is cleared whenever this block is reset.
- img_flat is not reset. It changes only on LOAD writes, so it is stable throughout CLEAR, RUN and HOLD.
- Reset mid-frame or mid-run: go to LOAD, cnt=0, timer=0, result_valid=0. Partial buffer contents are don't-care.

## Timing
- Reset values: s_ready 0 during reset and 1 on the first cycle after. nn_enable 0, nn_reset 1 while reset is high. result_valid 0, result_digit 0, frame_error 0, busy 0.
- Throughput: 1 pixel per cycle in LOAD.
- Last-pixel acceptance at edge T:
  - CLEAR is in cycle T+1 (nn_reset=1).
  - RUN starts in T+2 (nn_enable=1).
- The network's done is registered and is therefore low in the first RUN cycle. No stale done is consumed.
- nn_done high sampled at edge D:
  - result_valid=1 and result_digit are updated from cycle D+1.
  - nn_enable=0 from cycle D+1.
- result_ack sampled high at edge A:
  - result_valid=0 and s_ready=1 from cycle A+1.
  - Ack in the first HOLD cycle is honoured.
- result_ack outside HOLD is ignored.
- frame_error is high for exactly the cycle after the offending edge.
- s_valid with s_ready=0 is not consumed. The source must hold data.

## Test plan
- Clean frame: 784 beats of s_data=k[7:0], s_last on beat 783, network model asserts done 50 cycles into RUN with digit 7 -> img_flat byte k = k mod 256; nn_reset one cycle; result_valid with result_digit=7; busy high CLEAR..HOLD.
- Short frame: s_last on beat 99, then a clean frame -> frame_error pulse at beat 99; no CLEAR; second frame completes normally.
- Long frame: 790 beats with s_last on beat 789, then a clean frame -> frame_error after beat 783; beats 784..789 do not alter the buffer; clean frame recognised.
- Backpressure and hold: s_valid toggled 50% during load; result_ack delayed 20 cycles with s_valid asserted -> no beats accepted in CLEAR/RUN/HOLD; result_valid held 20 cycles; s_ready=1 the cycle after the ack.
- Timeout: NN_TIMEOUT=100, network never done -> frame_error in RUN cycle 100; result_valid stays 0; returns to LOAD.
- Reset mid-run: assert reset at RUN cycle 10, then a clean frame -> nn_reset high during reset; after reset s_ready=1, cnt restarts at 0; correct digit returned.

Source files
------------

// File: rtl/nn_frame_loader_if.sv
// Byte-serial pixel stream from the host link into the frame loader.
interface nn_frame_loader_if #(
  parameter int PIX_W = 8
);
  logic             valid;
  logic [PIX_W-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/nn_frame_loader.sv
// Loads a row-major grayscale frame into a flat pixel buffer, then sequences the
// digit network through reset/enable/done and holds the result until acknowledged.
module nn_frame_loader #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int PIX_W      = 8,
  parameter int NN_TIMEOUT = 200000
) (
  input  logic                         clk,
  input  logic                         reset,
  nn_frame_loader_if.slave             pix,
  output logic [PIX_W*IMG_W*IMG_H-1:0] img_flat,
  output logic                         nn_reset,
  output logic                         nn_enable,
  input  logic [7:0]                   nn_digit,
  input  logic                         nn_done,
  output logic                         result_valid,
  output logic [7:0]                   result_digit,
  input  logic                         result_ack,
  output logic                         frame_error,
  output logic                         busy
);
  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam int TMR_W = (NN_TIMEOUT > 2) ? $clog2(NN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(NN_TIMEOUT - 1);

  typedef enum logic [2:0] {LOAD, SYNC, CLEAR, RUN, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  logic             ready_q;
  logic             clear_q;
  logic             take;

  // ready_q tracks LOAD/SYNC; reset masks it combinationally so nothing is taken while held
  assign pix.ready = ready_q && !reset;
  assign take      = pix.valid && pix.ready;
  assign nn_reset  = reset || clear_q;

  // Pixel buffer carries no reset: only LOAD writes touch it
  always_ff @(posedge clk) begin
    if (take && state == LOAD) begin
      img_flat[int'(cnt)*PIX_W +: PIX_W] <= pix.data;
    end
  end

  always_ff @(posedge clk) begin
    frame_error <= 1'b0;
    if (reset) begin
      state        <= LOAD;
      cnt          <= '0;
      timer        <= '0;
      ready_q      <= 1'b1;
      clear_q      <= 1'b0;
      nn_enable    <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (take) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (pix.last) begin
                state   <= CLEAR;
                clear_q <= 1'b1;
                busy    <= 1'b1;
                ready_q <= 1'b0;
              end else begin
                // Long frame: drop the excess beats up to the source's own frame end
                state       <= SYNC;
                frame_error <= 1'b1;
              end
            end else if (pix.last) begin
              cnt         <= '0;
              frame_error <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SYNC: begin
          if (take && pix.last) state <= LOAD;
        end
        CLEAR: begin
          state     <= RUN;
          clear_q   <= 1'b0;
          nn_enable <= 1'b1;
          timer     <= '0;
        end
        RUN: begin
          // A done arriving on the final timer cycle still wins over the timeout
          if (nn_done) begin
            state        <= HOLD;
            result_digit <= nn_digit;
            result_valid <= 1'b1;
            nn_enable    <= 1'b0;
          end else if (timer == TMR_LAST) begin
            state       <= LOAD;
            frame_error <= 1'b1;
            nn_enable   <= 1'b0;
            busy        <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD: begin
          if (result_ack) begin
            state        <= LOAD;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_frame_loader.sv
// Randomized frame-level bench: a frame model predicts buffer contents and result/error
// events into a queue that a negedge monitor drains against the loader's outputs.
module tb_nn_frame_loader;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 8;
  localparam int N     = IMG_W * IMG_H;
  localparam int TO    = 100;
  localparam int BOUND = 2000;
  localparam int K_RES = 0;
  localparam int K_ERR = 1;

  typedef struct {
    int                 kind;
    int                 digit;
    int                 run;
    logic [PIX_W*N-1:0] img;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [PIX_W*N-1:0] img_flat;
  logic               nn_reset, nn_enable, nn_done, result_valid, result_ack, frame_error, busy;
  logic [7:0]         nn_digit, result_digit;

  int          passed = 0;
  int          total  = 0;
  exp_t        exp_q[$];
  byte unsigned ref_img[N];
  int          done_at   = 0;
  logic [7:0]  cur_digit = 8'd0;
  int          ecnt;
  int          mon_run   = 0;
  logic        mon_rv    = 1'b0;
  exp_t        mon_e;

  nn_frame_loader_if #(.PIX_W(PIX_W)) pix();

  nn_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .NN_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix          (pix),
    .img_flat     (img_flat),
    .nn_reset     (nn_reset),
    .nn_enable    (nn_enable),
    .nn_digit     (nn_digit),
    .nn_done      (nn_done),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .result_ack   (result_ack),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Network stand-in: done rises in its done_at-th enabled cycle; digit is junk until done
  assign nn_digit = nn_done ? cur_digit : ~cur_digit;
  always @(posedge clk) begin
    if (nn_reset) begin
      ecnt    <= 0;
      nn_done <= 1'b0;
    end else if (nn_enable) begin
      ecnt    <= ecnt + 1;
      nn_done <= (done_at != 0) && (ecnt + 2 >= done_at);
    end
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [PIX_W*N-1:0] ref_vec();
    logic [PIX_W*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*PIX_W +: PIX_W] = ref_img[k];
    return v;
  endfunction

  task automatic chk_img(input string name, input logic [PIX_W*N-1:0] want);
    int diff = -1;
    int idx;
    for (int k = 0; k < N; k++)
      if (diff < 0 && img_flat[k*PIX_W +: PIX_W] !== want[k*PIX_W +: PIX_W]) diff = k;
    idx = (diff < 0) ? 0 : diff;
    chk(diff < 0, name, img_flat[idx*PIX_W +: PIX_W], want[idx*PIX_W +: PIX_W]);
  endtask

  task automatic finish_now();
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "run stopped early");
  endtask

  // Monitor: pops one expectation per result or frame_error cycle
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_run = 0;
        mon_rv  = 1'b0;
      end else begin
        if (nn_enable) mon_run++;
        if (frame_error) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_frame_error", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk(mon_e.kind == K_ERR, "event_kind_error", K_ERR, mon_e.kind);
            if (mon_e.run >= 0) chk(mon_run == mon_e.run, "timeout_run_cycles", mon_run, mon_e.run);
          end
        end
        if (result_valid && !mon_rv) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_result", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk(mon_e.kind == K_RES, "event_kind_result", K_RES, mon_e.kind);
            chk(result_digit == 8'(mon_e.digit), "result_digit", result_digit, mon_e.digit);
            chk(mon_run == mon_e.run, "run_cycles_to_done", mon_run, mon_e.run);
            chk(!nn_enable, "enable_low_in_hold", nn_enable, 0);
            chk_img("img_flat_in_hold", mon_e.img);
          end
        end
        mon_rv = result_valid;
        if (nn_reset) mon_run = 0;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input bit last, input bit bp);
    int w = 0;
    if (bp && $urandom_range(0, 1) == 1) begin
      pix.valid = 1'b0;
      @(negedge clk);
    end
    pix.valid = 1'b1;
    pix.data  = d;
    pix.last  = last;
    while (!pix.ready) begin
      @(negedge clk);
      w++;
      if (w > BOUND) begin
        chk(1'b0, "beat_accept_timeout", w, BOUND);
        finish_now();
      end
    end
    @(negedge clk);
    pix.valid = 1'b0;
    pix.last  = 1'b0;
  endtask

  // One frame of len beats; the model decides the outcome from length and done_at alone
  task automatic run_frame(input int len, input bit incr, input int digit, input int d_at,
                           input int ack_dly, input bit bp, input bit hold_valid,
                           input bit stray_ack, input bit abort);
    logic [7:0] fd [800];
    exp_t e;
    int   w;
    bit   ok_rdy;
    bit   ok_hold;
    for (int k = 0; k < len; k++) fd[k] = incr ? 8'(k) : 8'($urandom_range(0, 255));
    for (int k = 0; k < len && k < N; k++) ref_img[k] = fd[k];
    done_at   = d_at;
    cur_digit = 8'(digit);
    e.digit = digit;
    e.img   = ref_vec();
    e.run   = -1;
    e.kind  = K_ERR;
    if (len == N && d_at != 0) begin
      e.kind = K_RES;
      e.run  = d_at;
    end else if (len == N) begin
      e.run = TO;
    end
    if (!abort) exp_q.push_back(e);

    for (int k = 0; k < len; k++) send_beat(fd[k], k == len - 1, bp);

    if (len != N) begin
      chk(!busy && !nn_reset, "no_clear_after_bad_frame", {busy, nn_reset}, 0);
      chk_img("img_after_bad_frame", ref_vec());
      return;
    end
    if (hold_valid) begin
      pix.valid = 1'b1;
      pix.data  = 8'hA5;
      pix.last  = 1'b0;
    end
    chk(nn_reset && busy && !nn_enable && !pix.ready, "clear_cycle",
        {nn_reset, busy, nn_enable, pix.ready}, 4'b1100);
    @(negedge clk);
    chk(nn_enable && !nn_reset && busy, "run_first_cycle", {nn_enable, nn_reset, busy}, 3'b101);

    if (abort) begin
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk(nn_reset && !pix.ready && !nn_enable && !busy && !result_valid, "midrun_reset_state",
          {nn_reset, pix.ready, nn_enable, busy, result_valid}, 5'b10000);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk(pix.ready && !nn_reset && !busy, "ready_after_midrun_reset", {pix.ready, nn_reset, busy}, 3'b100);
      return;
    end

    if (d_at == 0) begin
      w = 0;
      while (busy && w < TO + 20) begin
        @(negedge clk);
        w++;
      end
      chk(!busy && !result_valid && pix.ready, "timeout_return_to_load",
          {busy, result_valid, pix.ready}, 3'b001);
      return;
    end

    w = 0;
    ok_rdy = 1'b1;
    while (!result_valid && w < TO + 20) begin
      ok_rdy &= !pix.ready;
      result_ack = stray_ack && (w == 5);
      @(negedge clk);
      w++;
    end
    result_ack = 1'b0;
    chk(result_valid, "result_arrives", result_valid, 1);
    if (hold_valid) chk(ok_rdy, "no_ready_in_run", ok_rdy, 1);
    ok_hold = 1'b1;
    repeat (ack_dly) begin
      ok_hold &= result_valid && busy && !pix.ready && !nn_enable;
      @(negedge clk);
    end
    chk(ok_hold, "result_held_until_ack", ok_hold, 1);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk(!result_valid && pix.ready && !busy, "ack_returns_to_load",
        {result_valid, pix.ready, busy}, 3'b010);
    pix.valid = 1'b0;
  endtask

  initial begin
    pix.valid  = 1'b0;
    pix.data   = '0;
    pix.last   = 1'b0;
    result_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk(!pix.ready, "reset_s_ready", pix.ready, 0);
    chk(nn_reset && !nn_enable, "reset_nn_ctrl", {nn_reset, nn_enable}, 2'b10);
    chk(!result_valid && result_digit == 8'd0, "reset_result", {result_valid, result_digit}, 0);
    chk(!frame_error && !busy, "reset_flags", {frame_error, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk(pix.ready && !nn_reset, "ready_after_reset", {pix.ready, nn_reset}, 2'b10);

    run_frame(N, 1'b1, 7, 50, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(N, 1'b0, 3, 40, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(790, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(N, 1'b0, 9, 25, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(N, 1'b0, 4, 60, 20, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(N, 1'b0, 5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(N, 1'b0, 2, TO, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(N, 1'b0, 6, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(N, 1'b1, 8, 30, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      run_frame(N, 1'b0, $urandom_range(0, 255), $urandom_range(2, TO), $urandom_range(0, 5),
                1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
